// File: rtl/signed_seq_divider.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor, one restoring quotient bit per clock.
// Optional build macro DIV_ZERO_FAST_EN shortens divide-by-zero operations to a 2-cycle latency.
module signed_seq_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] dvd_mag;
  logic [W-1:0]   dvs_mag;
  logic [W-1:0]   prem;
  logic [W-1:0]   dvd_lo;
  logic           sgn_dvd, sgn_dvs, dz;

  logic           accept, last;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   prem_nxt;

  logic           qneg, ovf_c;
  logic [2*W-1:0] lim_pos, lim_neg;
  logic [W-1:0]   q_fix, r_fix;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(2*W-1));
  assign busy   = (state != IDLE);

  // Restoring step: shift one dividend bit into the partial remainder and trial-subtract.
  assign shifted  = {prem, dvd_mag[2*W-1]};
  assign ge       = (shifted >= {1'b0, dvs_mag});
  assign prem_nxt = ge ? W'(shifted - {1'b0, dvs_mag}) : shifted[W-1:0];

  assign qneg    = sgn_dvd ^ sgn_dvs;
  assign lim_pos = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  assign lim_neg = lim_pos + 1'b1;
  assign ovf_c   = !dz && (qneg ? (dvd_mag > lim_neg) : (dvd_mag > lim_pos));

  always_comb begin
    q_fix = '0;
    r_fix = '0;
    if (dz) begin
      q_fix = '0;
      r_fix = dvd_lo;
    end else begin
      if (ovf_c)
        q_fix = qneg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        q_fix = qneg ? -dvd_mag[W-1:0] : dvd_mag[W-1:0];
      r_fix = sgn_dvd ? -prem : prem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      dvd_lo      <= '0;
      sgn_dvd     <= 1'b0;
      sgn_dvs     <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd_mag <= dividend[2*W-1] ? -dividend : dividend;
        dvs_mag <= divisor[W-1] ? -divisor : divisor;
        sgn_dvd <= dividend[2*W-1];
        sgn_dvs <= divisor[W-1];
        dz      <= (divisor == '0);
        dvd_lo  <= dividend[W-1:0];
        prem    <= '0;
`ifdef DIV_ZERO_FAST_EN
        // Zero divisor: preload the counter so CALC is left after a single pass.
        cnt     <= (divisor == '0) ? CW'(2*W-1) : '0;
`else
        cnt     <= '0;
`endif
      end else if (state == CALC) begin
        prem    <= prem_nxt;
        dvd_mag <= {dvd_mag[2*W-2:0], ge};
        cnt     <= cnt + 1'b1;
      end else if (state == FIX) begin
        done        <= 1'b1;
        quotient    <= q_fix;
        remainder   <= r_fix;
        overflow    <= ovf_c;
        div_by_zero <= dz;
      end
    end
  end

endmodule
